// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory boot path
//
// Contents:
//   loader_state_t : boot loader FSM states
//   NOP_INSTR      : instruction word presented while fetch is flushed
//                    (shared with instr_memory_seq)
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time program streamer into the instruction memory write port
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start_load, len : request to (re)load len words (len sampled on accept)
//   s_data/s_valid/s_ready : incoming program word stream
//   imem_instr_in, imem_wr_addr, imem_wr_en, imem_flush : to instr_memory_seq
//   cpu_hold        : stalls PC/pipeline while the image is incomplete
//   load_done       : 1-cycle pulse on the first RUN cycle
//   load_err        : 1-cycle pulse when a start_load is rejected (len > SIZE)
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 2**10,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_load,
    input  logic [LOGSIZE:0]   len,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [WIDTH-1:0]   imem_instr_in,
    output logic [LOGSIZE+1:0] imem_wr_addr,
    output logic               imem_wr_en,
    output logic               imem_flush,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);

    localparam logic [LOGSIZE:0] MAX_LEN = (LOGSIZE+1)'(SIZE);
    localparam logic [LOGSIZE:0] ONE     = (LOGSIZE+1)'(1);

    loader_state_t    state;
    logic [LOGSIZE:0] count;
    logic [LOGSIZE:0] remaining;
    logic             handshake;

    // s_ready is the only combinational output: it must track the state
    // in the same cycle so a word is never accepted outside LOAD.
    assign s_ready   = (state == LOAD);
    assign handshake = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            remaining     <= '0;
            imem_wr_en    <= 1'b0;
            imem_wr_addr  <= '0;
            imem_instr_in <= '0;
            imem_flush    <= 1'b1;
            cpu_hold      <= 1'b1;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;

            case (state)
                IDLE, RUN: begin
                    if (start_load) begin
                        if (len > MAX_LEN) begin
                            // Rejected: stay where we are, RUN keeps running.
                            load_err <= 1'b1;
                        end else begin
                            count      <= '0;
                            remaining  <= len;
                            cpu_hold   <= 1'b1;
                            imem_flush <= 1'b1;
                            state      <= (len == '0) ? DRAIN : LOAD;
                        end
                    end
                end

                LOAD: begin
                    // start_load is deliberately not looked at here.
                    if (handshake) begin
                        imem_wr_en    <= 1'b1;
                        imem_instr_in <= s_data;
                        imem_wr_addr  <= {count[LOGSIZE-1:0], 2'b00};
                        count         <= count + ONE;
                        remaining     <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The last registered write lands this cycle while the
                    // pipeline is still held; release on the next edge.
                    state      <= RUN;
                    load_done  <= 1'b1;
                    cpu_hold   <= 1'b0;
                    imem_flush <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 1024;
    localparam int LOGSIZE = $clog2(SIZE);

    logic               clk = 1'b0;
    logic               rst;
    logic               start_load;
    logic [LOGSIZE:0]   len;
    logic [WIDTH-1:0]   s_data;
    logic               s_valid;
    logic               s_ready;
    logic [WIDTH-1:0]   imem_instr_in;
    logic [LOGSIZE+1:0] imem_wr_addr;
    logic               imem_wr_en;
    logic               imem_flush;
    logic               cpu_hold;
    logic               load_done;
    logic               load_err;

    imem_boot_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_load    (start_load),
        .len           (len),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .imem_instr_in (imem_instr_in),
        .imem_wr_addr  (imem_wr_addr),
        .imem_wr_en    (imem_wr_en),
        .imem_flush    (imem_flush),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a load is "words still owed", then a one-cycle
    // settle, then the CPU is released. Expected registered outputs are
    // computed per edge from those facts.
    // ------------------------------------------------------------------
    bit     m_on       = 0;
    bit     m_loading  = 0;
    bit     m_settling = 0;
    bit     m_released = 0;
    int     m_left     = 0;
    int     m_idx      = 0;
    bit     e_wr_en    = 0;
    longint e_addr     = 0;
    longint e_data     = 0;
    bit     e_hold     = 1;
    bit     e_done     = 0;
    bit     e_err      = 0;
    logic [WIDTH-1:0] exp_mem [SIZE];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_on = 1; m_loading = 0; m_settling = 0; m_released = 0;
                m_idx = 0; m_left = 0;
                e_wr_en = 0; e_addr = 0; e_data = 0; e_hold = 1; e_done = 0; e_err = 0;
            end else begin
                e_wr_en = 0; e_done = 0; e_err = 0;
                if (m_loading) begin
                    if (s_valid) begin
                        e_wr_en = 1;
                        e_data  = s_data;
                        e_addr  = 4 * m_idx;
                        exp_mem[m_idx] = s_data;
                        m_idx++;
                        m_left--;
                        if (m_left == 0) begin
                            m_loading  = 0;
                            m_settling = 1;
                        end
                    end
                end else if (m_settling) begin
                    m_settling = 0;
                    m_released = 1;
                    e_done     = 1;
                end else if (start_load) begin
                    if (int'(len) > SIZE) begin
                        e_err = 1;
                    end else begin
                        m_released = 0;
                        m_idx      = 0;
                        m_left     = int'(len);
                        if (len == 0) m_settling = 1;
                        else          m_loading  = 1;
                    end
                end
                e_hold = !m_released;
            end
        end
    end

    // Write log and shadow memory built from the DUT's write port.
    logic [LOGSIZE+1:0] log_addr[$];
    logic [WIDTH-1:0]   log_data[$];
    logic [WIDTH-1:0]   dut_mem [SIZE];

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                check("s_ready",   s_ready,    m_loading);
                check("wr_en",     imem_wr_en, e_wr_en);
                check("cpu_hold",  cpu_hold,   e_hold);
                check("flush",     imem_flush, e_hold);
                check("load_done", load_done,  e_done);
                check("load_err",  load_err,   e_err);
                if (e_wr_en) begin
                    check("wr_addr",  imem_wr_addr,  e_addr);
                    check("instr_in", imem_instr_in, e_data);
                end
            end
            if (imem_wr_en) begin
                log_addr.push_back(imem_wr_addr);
                log_data.push_back(imem_instr_in);
                dut_mem[imem_wr_addr[LOGSIZE+1:2]] = imem_instr_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int l);
        start_load = 1'b1;
        len        = (LOGSIZE+1)'(l);
        tick();
        start_load = 1'b0;
    endtask

    // mode 0: valid every cycle; 1: valid pattern 1,0,0,1,0,1; 2: random valid.
    // data_base != 0 gives data_base+i, otherwise random words.
    task automatic send(input int n, input int mode, input bit hold_start,
                        input logic [WIDTH-1:0] data_base);
        int  got;
        int  cyc;
        bit  hs;
        bit  pat[6];
        got = 0;
        cyc = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        while (got < n && cyc < 8000) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = pat[cyc % 6];
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = (data_base != 0) ? data_base + WIDTH'(got) : WIDTH'($urandom);
            if (hold_start) start_load = 1'b1;
            hs = s_valid && s_ready;
            tick();
            if (hs) got++;
            cyc++;
        end
        s_valid    = 1'b0;
        start_load = 1'b0;
        if (got < n) check("send_timeout", got, n);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!load_done && cyc < 50);
        if (!load_done) check("load_done_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    int cyc;

    initial begin
        rst = 1'b1; start_load = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) tick();
        check("rst_hold",   cpu_hold,   1);
        check("rst_flush",  imem_flush, 1);
        check("rst_ready",  s_ready,    0);
        check("rst_wr_en",  imem_wr_en, 0);
        check("rst_done",   load_done,  0);
        rst = 1'b0;

        // Four words back-to-back.
        log_addr.delete(); log_data.delete();
        start(4);
        send(4, 0, 1'b0, 32'hA0A0_0000);
        check("s1_drain_wr_en", imem_wr_en, 1);
        check("s1_drain_hold",  cpu_hold,   1);
        wait_done(cyc);
        check("s1_drain_cycles", cyc, 1);
        check("s1_hold_released", cpu_hold, 0);
        check("s1_nwrites", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("s1_addr", log_addr[i], 4 * i);
            check("s1_data", log_data[i], 32'hA0A0_0000 + i);
        end
        check("s1_word0", dut_mem[0], 32'hA0A0_0000);

        // Three words with a gappy valid.
        log_addr.delete(); log_data.delete();
        start(3);
        send(3, 1, 1'b0, 32'hB000_0000);
        wait_done(cyc);
        check("s2_nwrites", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) check("s2_addr", log_addr[i], 4 * i);

        // Oversize rejected from IDLE, then a full-size load.
        do_reset(1);
        log_addr.delete(); log_data.delete();
        start(SIZE + 1);
        check("s3_err",   load_err, 1);
        check("s3_hold",  cpu_hold, 1);
        check("s3_ready", s_ready,  0);
        tick();
        check("s3_err_pulse", load_err, 0);
        check("s3_nwrites_err", log_addr.size(), 0);
        start(SIZE);
        send(SIZE, 2, 1'b0, '0);
        wait_done(cyc);
        check("s3_nwrites", log_addr.size(), SIZE);
        check("s3_last_addr", log_addr[SIZE-1], 4 * (SIZE - 1));

        // Zero-length load.
        log_addr.delete(); log_data.delete();
        start(0);
        wait_done(cyc);
        check("s4_done_after_2", cyc + 1, 2);
        check("s4_nwrites", log_addr.size(), 0);

        // Reset after 2 of 5 words.
        start(5);
        send(2, 0, 1'b0, 32'hC000_0000);
        do_reset(1);
        check("s5_ready", s_ready,    0);
        check("s5_hold",  cpu_hold,   1);
        check("s5_wr_en", imem_wr_en, 0);
        log_addr.delete(); log_data.delete();
        start(5);
        send(5, 2, 1'b0, 32'hD000_0000);
        wait_done(cyc);
        check("s5_nwrites", log_addr.size(), 5);
        check("s5_first_addr", log_addr[0], 0);

        // Reload from RUN with start_load held during LOAD.
        log_addr.delete(); log_data.delete();
        start(2);
        check("s6_hold",  cpu_hold,   1);
        check("s6_flush", imem_flush, 1);
        send(2, 0, 1'b1, 32'hE000_0000);
        wait_done(cyc);
        check("s6_nwrites", log_addr.size(), 2);
        check("s6_addr0", log_addr[0], 0);
        check("s6_addr1", log_addr[1], 4);
        check("s6_word0", dut_mem[0], 32'hE000_0000);

        // Randomised loads checked cycle-by-cycle by the model.
        for (int it = 0; it < 30; it++) begin
            int l;
            int r;
            r = $urandom_range(0, 9);
            l = (r == 0) ? SIZE + 1 + $urandom_range(0, 100) : $urandom_range(0, 12);
            repeat ($urandom_range(0, 3)) tick();
            start(l);
            if (l > SIZE) begin
                tick();
            end else if (r == 1 && l > 1) begin
                send(l / 2, 2, 1'b0, '0);
                do_reset($urandom_range(1, 2));
            end else begin
                if (l > 0) send(l, 2, $urandom_range(0, 1) == 1, '0);
                wait_done(cyc);
                for (int i = 0; i < l; i++) check("rnd_mem", dut_mem[i], exp_mem[i]);
            end
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
